// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and the small-sigma message-schedule functions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sha256_pkg;

  localparam int WORD_SIZE = 32;
  localparam int ROUNDS    = 64;

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef word_t [0:15]         block_t;   // element 0 occupies the MSBs

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational next-schedule-word unit: W[t+16] from W[t], W[t+1], W[t+9], W[t+14].
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is used.
// Ports: w0/w1/w9/w14 = window taps, w_next = sigma1(w14)+w9+sigma0(w1)+w0 mod 2^32.
module sha256_w_expand
  import sha256_pkg::*;
(
  input  logic [WORD_SIZE-1:0] w0,
  input  logic [WORD_SIZE-1:0] w1,
  input  logic [WORD_SIZE-1:0] w9,
  input  logic [WORD_SIZE-1:0] w14,
  output logic [WORD_SIZE-1:0] w_next
);

  // Carries out of bit 31 drop naturally at the 32-bit result width.
  assign w_next = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: takes one 512-bit padded block, emits W[0..63] one word per handshake.
// Latency: W[0] valid the cycle after block acceptance; one bubble between blocks (zero with preload).
// Backpressure: w_ready low freezes window, counter and all word outputs; blk_ready low while busy.
// Ports: clk/rst (async active-high), blk_valid/blk_ready/blk_data (word 0 = bits [511:480]),
//        w_valid/w_ready/w_data/w_idx/w_last (schedule word stream), busy (block in progress).
// Optional macro SHA256_SCHED_PRELOAD_EN: adds a one-block preload buffer so a second block can be
// accepted during RUN and streamed back-to-back with no bubble.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   blk_valid,
  output logic                   blk_ready,
  input  logic [16*WORD_SIZE-1:0] blk_data,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic [WORD_SIZE-1:0]   w_data,
  output logic [5:0]             w_idx,
  output logic                   w_last,
  output logic                   busy
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  sched_state_t state_q, state_d;
  block_t       win_q, win_d;
  logic [5:0]   t_q, t_d;
  word_t        w_new;
  block_t       blk_in;
  logic         w_hs, blk_hs, at_last;

`ifdef SHA256_SCHED_PRELOAD_EN
  block_t       pre_q, pre_d;
  logic         pre_full_q, pre_full_d;
`endif

  sha256_w_expand u_expand (
    .w0     (win_q[0]),
    .w1     (win_q[1]),
    .w9     (win_q[9]),
    .w14    (win_q[14]),
    .w_next (w_new)
  );

  // All word-side outputs come straight from flops, so w_ready never reaches w_data.
  assign busy    = (state_q == RUN);
  assign w_valid = busy;
  assign w_data  = win_q[0];
  assign w_idx   = t_q;
  assign w_last  = busy && (t_q == LAST_IDX);

`ifdef SHA256_SCHED_PRELOAD_EN
  assign blk_ready = (state_q == IDLE) || !pre_full_q;
`else
  assign blk_ready = (state_q == IDLE);
`endif

  assign blk_in  = block_t'(blk_data);
  assign w_hs    = w_valid && w_ready;
  assign blk_hs  = blk_valid && blk_ready;
  assign at_last = (t_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    t_d     = t_q;
`ifdef SHA256_SCHED_PRELOAD_EN
    pre_d      = pre_q;
    pre_full_d = pre_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (blk_hs) begin
          win_d   = blk_in;
          t_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (w_hs && at_last) begin
          t_d = '0;
`ifdef SHA256_SCHED_PRELOAD_EN
          if (pre_full_q) begin
            win_d      = pre_q;
            pre_full_d = 1'b0;
          end else if (blk_hs) begin
            // Arrival coincides with the last word: bypass the empty preload buffer.
            win_d = blk_in;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else if (w_hs) begin
          // Slide the window; words generated past W[63] are simply never emitted.
          for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[15] = w_new;
          t_d       = t_q + 6'd1;
        end
`ifdef SHA256_SCHED_PRELOAD_EN
        if (blk_hs && !(w_hs && at_last)) begin
          pre_d      = blk_in;
          pre_full_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      t_q     <= '0;
`ifdef SHA256_SCHED_PRELOAD_EN
      pre_q      <= '0;
      pre_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      t_q     <= t_d;
`ifdef SHA256_SCHED_PRELOAD_EN
      pre_q      <= pre_d;
      pre_full_q <= pre_full_d;
`endif
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: textbook W[t] recurrence model plus expected-word queue.
// Latency: n/a (testbench).
// Backpressure: w_ready driven constant-high or randomly per phase.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;
  logic         busy;

  sha256_msg_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_idx     (w_idx),
    .w_last    (w_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] w;
    logic [5:0]  i;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl[64];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          hs_count = 0;
  int          last_hs_cyc = -1;
  int          gap = -1;
  logic [31:0] dut_w17 = '0;
  bit          rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook schedule: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
  function automatic void run_model(input logic [511:0] b);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) mdl[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(mdl[t-15], 7) ^ ror(mdl[t-15], 18) ^ (mdl[t-15] >> 3);
      s1 = ror(mdl[t-2], 17) ^ ror(mdl[t-2], 19) ^ (mdl[t-2] >> 10);
      mdl[t] = s1 + mdl[t-7] + s0 + mdl[t-16];
    end
  endfunction

  function automatic logic [511:0] rnd_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Compare process: every negedge, DUT outputs vs. queue of words still owed.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        last_hs_cyc = -1;
      end else begin
        check("w_valid", w_valid, exp_q.size() != 0);
        check("busy", busy, exp_q.size() != 0);
`ifdef SHA256_SCHED_PRELOAD_EN
        check("blk_ready", blk_ready, exp_q.size() <= 64);
`else
        check("blk_ready", blk_ready, exp_q.size() == 0);
`endif
        if (w_valid && exp_q.size() != 0) begin
          check("w_data", w_data, exp_q[0].w);
          check("w_idx", w_idx, exp_q[0].i);
          check("w_last", w_last, exp_q[0].i == 6'd63);
          if (w_idx == 6'd0 && last_hs_cyc >= 0) begin
            gap = cyc - last_hs_cyc - 1;
            last_hs_cyc = -1;
          end
          if (w_ready) begin
            hs_count++;
            if (w_idx == 6'd17) dut_w17 = w_data;
            if (w_last) last_hs_cyc = cyc;
            void'(exp_q.pop_front());
          end
        end
        if (blk_valid && blk_ready) begin
          run_model(blk_data);
          for (int i = 0; i < 64; i++) exp_q.push_back('{w: mdl[i], i: 6'(i)});
        end
      end
    end
  end

  // w_ready driver
  initial begin
    w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      w_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_block(input logic [511:0] b, input bit scramble);
    blk_valid = 1'b1;
    blk_data  = b;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (blk_ready) begin
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        blk_data  = rnd_blk();
        return;
      end
      @(posedge clk);
      #1;
      if (scramble) blk_data = rnd_blk();
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_block: block not accepted within 400 cycles");
    blk_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !w_valid) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_done: stream did not drain within 3000 cycles");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_blk_ready"}, blk_ready, 1'b1);
    check({tag, "_w_valid"}, w_valid, 1'b0);
    check({tag, "_w_data"}, w_data, 32'h0);
    check({tag, "_w_idx"}, w_idx, 6'd0);
    check({tag, "_w_last"}, w_last, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  logic [511:0] abc, b1, b2;
  int           h0;
  bit           found;

  initial begin
    rst       = 1'b1;
    blk_valid = 1'b0;
    blk_data  = '0;
    abc       = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0]    = 32'h00000018;

    // Pin the model with hand-derived words of the "abc" block.
    run_model(abc);
    check("model_w0", mdl[0], 32'h61626380);
    check("model_w15", mdl[15], 32'h00000018);
    check("model_w16", mdl[16], 32'h61626380);
    check("model_w17", mdl[17], 32'h000F0000);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // "abc" block, no stalls
    h0 = hs_count;
    send_block(abc, 1'b0);
    wait_done();
    check("abc_handshakes", hs_count - h0, 64);
    check("abc_dut_w17", dut_w17, 32'h000F0000);

    // all-zero block
    h0 = hs_count;
    send_block('0, 1'b0);
    wait_done();
    check("zero_handshakes", hs_count - h0, 64);

    // random block under random backpressure, then same block without stalls
    b1 = rnd_blk();
    rand_rdy = 1'b1;
    h0 = hs_count;
    send_block(b1, 1'b0);
    wait_done();
    rand_rdy = 1'b0;
    check("stall_handshakes", hs_count - h0, 64);
    send_block(b1, 1'b0);
    wait_done();

    // asynchronous reset mid-block at t = 30
    send_block(rnd_blk(), 1'b0);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (w_valid && w_idx == 6'd30) found = 1'b1;
    end
    check("reached_t30", found, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    h0 = hs_count;
    send_block(rnd_blk(), 1'b0);
    wait_done();
    check("post_rst_handshakes", hs_count - h0, 64);

    // back-to-back blocks, blk_valid held; second block's data scrambled while waiting
    b1 = rnd_blk();
    b2 = rnd_blk();
    gap = -1;
    h0 = hs_count;
    send_block(b1, 1'b0);
    send_block(b2, 1'b1);
    wait_done();
    check("b2b_handshakes", hs_count - h0, 128);
`ifdef SHA256_SCHED_PRELOAD_EN
    check("b2b_gap", gap, 0);
`else
    check("b2b_gap", gap, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- Message-schedule stage directly upstream of the SHA-256 compression rounds.
- Accepts one 512-bit padded message block and emits the 64 schedule words W[0..63], one word per handshake, to the round engine.
- Uses a 16-word sliding window and the sigma0/sigma1 functions from sha256_pkg.

Parameters:
- WORD_SIZE, sha256_pkg::WORD_SIZE (32), width of one schedule word.
- ROUNDS, sha256_pkg::ROUNDS (64), number of words emitted per block.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- blk_valid  in  1  input block valid.
- blk_ready  out  1  block can be accepted.
- blk_data  in  16*WORD_SIZE  padded block; word 0 = bits [511:480], big-endian word order.
- w_valid  out  1  schedule word valid.
- w_ready  in  1  round engine accepts the word.
- w_data  out  WORD_SIZE  W[t].
- w_idx  out  6  t, range 0..63.
- w_last  out  1  high with t == ROUNDS-1.
- busy  out  1  a block is being scheduled.

Behaviour:
- Reset (async assert, sync deassert at the top level):
  - state = IDLE; window win[0..15] = 0; counter t = 0.
  - blk_ready = 1; w_valid = 0; w_data = 0; w_idx = 0; w_last = 0; busy = 0.
- FSM states: IDLE, RUN.
- IDLE:
  - blk_ready = 1.
  - On blk_valid && blk_ready: win[i] = blk_data word i, t = 0, go to RUN.
  - w_valid rises the cycle after acceptance (latency 1).
- RUN:
  - w_valid = 1; w_data = win[0]; w_idx = t; w_last = (t == 63); busy = 1.
  - blk_ready = 0 (unless the optional feature is enabled).
- Advance on w_valid && w_ready:
  - win[i] <= win[i+1] for i = 0..14.
  - win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], addition mod 2^32, carries discarded.
  - t <= t + 1.
  - Words computed beyond W[63] are never emitted.
- Stall (w_valid && !w_ready): w_data, w_idx, w_last, window and t all hold. No combinational path from w_ready to w_data.
- Block completion:
  - Handshake with t == 63 returns the FSM to IDLE.
  - w_valid = 0 next cycle; blk_ready = 1 next cycle.
  - Result: one bubble cycle between blocks.
- Counter t is 6 bits and never wraps during RUN; the block ends at 63.
- Upstream handshake rule: blk_data is sampled only on handshake and may change freely otherwise.
- blk_valid while in RUN: ignored and not accepted; the upstream source must hold it.
- Reset asserted mid-block: immediate return to reset values; the partial block is discarded and never resumed.
- Words 0..15 are the input words verbatim.

Optional Feature:
- Macro: SHA256_SCHED_PRELOAD_EN.
- Enabled:
  - Adds one 512-bit preload register plus a full flag.
  - In RUN, blk_ready = !pre_full; a handshake there fills the preload register.
  - On the t == 63 handshake with pre_full, the window loads from preload, t = 0, state stays RUN, pre_full clears.
  - Result: W[0] of the next block is valid the very next cycle (zero bubble).
  - Simultaneous t == 63 handshake and new block arrival with preload empty: the new block loads directly into the window.
  - Reset clears pre_full.
- Disabled: behaviour exactly as above, with no preload storage.

Decomposition:
- Use sha256_pkg for WORD_SIZE, ROUNDS, sigma0 and sigma1.
- Add to sha256_pkg:
  - typedef logic [WORD_SIZE-1:0] word_t.
  - typedef word_t [0:15] block_t.
  - the enum sched_state_t {IDLE, RUN}.
- One natural sub-module: sha256_w_expand, a combinational next-word unit taking win[0], win[1], win[9], win[14] and returning win[15]'s next value. Reusable by a future unrolled scheduler.

Test Plan:
- "abc" padded block (word0 = 32'h61626380, words 1..14 = 0, word15 = 32'h00000018), w_ready held 1:
  - W[0] = 61626380, W[15] = 00000018, W[16] = 61626380, W[17] = 000F0000.
  - w_idx counts 0..63; w_last only at 63.
  - W[0..63] match a C model.
- All-zero block: all 64 W = 0; exactly 64 handshakes, then blk_ready = 1 one cycle after w_last.
- Random w_ready (~50% duty) with a random block: w_data and w_idx stable during every stall; word sequence identical to the no-stall run.
- rst pulsed at t = 30: outputs return to reset values asynchronously. A following block restarts at W[0] = its word0 with no stale words.
- Two blocks back-to-back, blk_valid held:
  - Without SHA256_SCHED_PRELOAD_EN: exactly one w_valid = 0 cycle between w_last and the next W[0].
  - With the macro: zero gap; the second block is accepted during the first block's RUN.
- blk_valid asserted in RUN without the macro: blk_ready stays 0 and blk_data changes have no effect on the emitted words.
